// File: rtl/char_rx.sv
// char_rx: 8N1 serial character receiver, OVS clk cycles per bit, with
// start-bit glitch rejection and a BREAK state after a framing error.
module char_rx #(
    parameter int OVS = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        rxd,
    output logic [7:0]  char_out,
    output logic        char_valid,
    output logic        frame_err,
    output logic        busy,
    output logic [15:0] char_cnt
);
    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bidx, bidx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    char_out_n;
    logic          char_valid_n;
    logic          frame_err_n;
    logic [15:0]   char_cnt_n;
    logic          rxd_p0, rxd_s;

    // Stage p0 -> s: two-flop synchronizer, idles high
    always_ff @(posedge clk) begin
        if (clr) begin
            rxd_p0 <= 1'b1;
            rxd_s  <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_s  <= rxd_p0;
        end
    end

    // FSM state and output registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            cnt        <= '0;
            bidx       <= '0;
            shift      <= '0;
            char_out   <= '0;
            char_valid <= 1'b0;
            frame_err  <= 1'b0;
            char_cnt   <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bidx       <= bidx_n;
            shift      <= shift_n;
            char_out   <= char_out_n;
            char_valid <= char_valid_n;
            frame_err  <= frame_err_n;
            char_cnt   <= char_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        bidx_n       = bidx;
        shift_n      = shift;
        char_out_n   = char_out;
        char_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        char_cnt_n   = char_cnt;

        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                // Re-check the line half a bit in; a short low is treated as noise
                if (cnt == CNT_HALF) begin
                    cnt_n  = '0;
                    bidx_n = '0;
                    state_n = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    shift_n[bidx] = rxd_s;
                    cnt_n         = '0;
                    bidx_n        = bidx + 3'd1;
                    if (bidx == 3'd7)
                        state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (rxd_s) begin
                        char_out_n   = shift;
                        char_valid_n = 1'b1;
                        char_cnt_n   = char_cnt + 16'd1;
                        state_n      = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = BREAK;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BREAK: begin
                // A held-low line must go high before another start bit counts
                if (rxd_s)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_char_rx.sv
// Self-checking bench for char_rx: table-driven character strings, hand-written
// corner sequences and randomized frames checked against an event-queue model.
module tb_char_rx;
    localparam int OVS = 8;
    // drive-to-visible-pulse distance: raw sample + 2 sync flops + half bit + 9 bits
    localparam int LAT = 3 + OVS / 2 + 9 * OVS;

    logic        clk, clr, rxd;
    logic [7:0]  char_out;
    logic        char_valid, frame_err, busy;
    logic [15:0] char_cnt;

    char_rx #(.OVS(OVS)) dut (
        .clk       (clk),
        .clr       (clr),
        .rxd       (rxd),
        .char_out  (char_out),
        .char_valid(char_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .char_cnt  (char_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic [7:0]  exp_char;
        logic [15:0] exp_cnt;
    } vec_t;

    ev_t         ev_q[$];
    vec_t        tbl[8];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [15:0] mdl_cnt = '0;
    logic [7:0]  mdl_char = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock and compare any output pulse against the expected event queue
    task automatic tick();
        logic clr_edge;
        ev_t  e;
        @(posedge clk);
        clr_edge = clr;
        #1;
        cyc++;
        if (clr_edge) begin
            mdl_cnt  = '0;
            mdl_char = '0;
        end else if (char_valid || frame_err) begin
            check("pulse_exclusive", 32'(char_valid & frame_err), 32'd0);
            if (ev_q.size() == 0) begin
                check("unexpected_pulse", 32'({char_valid, frame_err}), 32'd0);
            end else begin
                e = ev_q.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                if (char_valid) begin
                    check("pulse_kind_valid", 32'(e.err), 32'd0);
                    mdl_cnt  = mdl_cnt + 16'd1;
                    mdl_char = e.data;
                    check("char_out", 32'(char_out), 32'(e.data));
                end else begin
                    check("pulse_kind_err", 32'(e.err), 32'd1);
                    check("char_out_held", 32'(char_out), 32'(mdl_char));
                end
                check("char_cnt", 32'(char_cnt), 32'(mdl_cnt));
            end
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) tick();
    endtask

    // One full 8N1 frame; an error frame may keep the line low afterwards
    task automatic send_frame(input logic [7:0] d, input logic stop, input int hold_low);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        ev_q.push_back('{err: ~stop, data: d, cyc: cyc + LAT});
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < OVS; j++) begin
                rxd = bits[i];
                tick();
            end
        end
        if (!stop) begin
            rxd = 1'b0;
            repeat (hold_low) tick();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_char_out"}, 32'(char_out), 32'd0);
        check({tag, "_char_valid"}, 32'(char_valid), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_char_cnt"}, 32'(char_cnt), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic       st;
        logic [9:0] bits;

        tbl[0] = '{8'h32, 1'b1, 8'h32, 16'd1};
        tbl[1] = '{8'h30, 1'b1, 8'h30, 16'd2};
        tbl[2] = '{8'h32, 1'b1, 8'h32, 16'd3};
        tbl[3] = '{8'h30, 1'b1, 8'h30, 16'd4};
        tbl[4] = '{8'h2F, 1'b1, 8'h2F, 16'd5};
        tbl[5] = '{8'h31, 1'b1, 8'h31, 16'd6};
        tbl[6] = '{8'h2F, 1'b1, 8'h2F, 16'd7};
        tbl[7] = '{8'h35, 1'b1, 8'h35, 16'd8};

        clr = 1'b1;
        rxd = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset_held");
        clr = 1'b0;
        repeat (4) tick();
        check_reset_outputs("reset_released");

        // Single character, latency checked by the event queue
        send_frame(8'h32, 1'b1, 0);
        check("single_char_out", 32'(char_out), 32'h32);
        check("single_char_cnt", 32'(char_cnt), 32'd1);
        idle(10);

        // "2020/1/5" back-to-back from a fresh counter
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("string_pre_cnt", 32'(char_cnt), 32'd0);
        idle(4);
        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].data, tbl[i].stop, 0);
            check("string_char_out", 32'(char_out), 32'(tbl[i].exp_char));
            check("string_char_cnt", 32'(char_cnt), 32'(tbl[i].exp_cnt));
        end
        idle(10);
        check("string_final_cnt", 32'(char_cnt), 32'd8);

        // Stop bit low, line held low for 30 cycles in total
        send_frame(8'h41, 1'b0, 0);
        for (int k = 0; k < 22; k++) begin
            rxd = 1'b0;
            tick();
            check("break_busy", 32'(busy), 32'd1);
        end
        rxd = 1'b1;
        tick();
        tick();
        check("break_busy_sync_delay", 32'(busy), 32'd1);
        tick();
        check("break_exit_busy", 32'(busy), 32'd0);
        check("break_char_out", 32'(char_out), 32'h35);
        check("break_char_cnt", 32'(char_cnt), 32'd8);
        idle(10);

        // Two-cycle low glitch
        rxd = 1'b0;
        tick();
        tick();
        rxd = 1'b1;
        tick();
        tick();
        check("glitch_start_busy", 32'(busy), 32'd1);
        idle(20);
        check("glitch_idle_busy", 32'(busy), 32'd0);
        check("glitch_char_cnt", 32'(char_cnt), 32'd8);

        // Reset during DATA bit 4, then a fresh frame
        bits = {1'b1, 8'h5A, 1'b0};
        for (int t = 0; t < 5 * OVS + OVS / 2; t++) begin
            rxd = bits[t / OVS];
            tick();
        end
        check("midframe_busy", 32'(busy), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        rxd = 1'b1;
        check_reset_outputs("midframe_clr");
        idle(12);
        send_frame(8'h39, 1'b1, 0);
        check("after_clr_char_out", 32'(char_out), 32'h39);
        check("after_clr_char_cnt", 32'(char_cnt), 32'd1);
        idle(6);

        // Randomized frames, stop errors and glitches
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                rxd = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                idle(10);
            end
            d  = 8'($urandom);
            st = ($urandom_range(0, 7) != 0);
            send_frame(d, st, st ? 0 : int'($urandom_range(0, 20)));
            idle(st ? int'($urandom_range(0, 4)) : int'($urandom_range(1, 6)));
        end
        idle(100);
        check("random_events_drained", 32'(ev_q.size()), 32'd0);
        check("random_char_cnt", 32'(char_cnt), 32'(mdl_cnt));
        check("random_char_out", 32'(char_out), 32'(mdl_char));

        // Counter wrap
        force dut.char_cnt = 16'hFFFF;
        tick();
        release dut.char_cnt;
        mdl_cnt = 16'hFFFF;
        tick();
        check("wrap_preload", 32'(char_cnt), 32'hFFFF);
        send_frame(8'h7E, 1'b1, 0);
        check("wrap_char_cnt", 32'(char_cnt), 32'h0000);
        check("wrap_char_out", 32'(char_out), 32'h7E);
        idle(5);
        check("final_events_drained", 32'(ev_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
